rv_regfile_sb: RTL and testbench

Parametrised integer register file with write-to-read bypass and a per-register pending-write scoreboard for the RV32IM pipeline. It sits between decode (read ports, issue) and writeback (write port). It supplies operands and per-operand busy flags so the hazard unit can stall without extra comparator logic. Register 0 is hard-wired to zero.

---
 rtl/rv_regfile_pkg.sv | 19 +
 rtl/rv_regfile_pend_cnt.sv | 32 +++
 rtl/rv_regfile_sb.sv | 65 ++++++
 tb/tb_rv_regfile_sb.sv | 123 ++++++++++++
 4 files changed

// File: rtl/rv_regfile_pkg.sv
// rv_regfile_pkg: shared defaults, width derivations and port-slice helper for the register file
package rv_regfile_pkg;
    localparam int XLEN_DEF     = 32;
    localparam int NREGS_DEF    = 32;
    localparam int PEND_MAX_DEF = 3;

    function automatic int aw_of(input int nregs);
        return $clog2(nregs);
    endfunction

    function automatic int cw_of(input int pend_max);
        return $clog2(pend_max + 1);
    endfunction

    // LSB of port i on a packed bus of w-bit fields
    function automatic int port_lsb(input int i, input int w);
        return i * w;
    endfunction
endpackage

// File: rtl/rv_regfile_pend_cnt.sv
// rv_regfile_pend_cnt: saturating pending-write counter for one architectural register
module rv_regfile_pend_cnt #(
    parameter int PEND_MAX = 3,
    parameter int CW       = 2
) (
    input  logic CLK,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    input  logic dec,
    output logic cnt_nz,
    output logic cnt_is_one,
    output logic full
);
    logic [CW-1:0] cnt;
    logic          dec_ok;

    // writebacks of squashed instructions find cnt==0 and must not underflow
    assign dec_ok     = dec && cnt != '0;
    assign cnt_nz     = cnt != '0;
    assign cnt_is_one = cnt == CW'(1);
    assign full       = cnt == CW'(PEND_MAX);

    always_ff @(posedge CLK) begin
        if (rst || clr)
            cnt <= '0;
        else if (inc && !dec_ok)
            cnt <= cnt + CW'(1);
        else if (!inc && dec_ok)
            cnt <= cnt - CW'(1);
    end
endmodule

// File: rtl/rv_regfile_sb.sv
// rv_regfile_sb: integer register file with write bypass and per-register pending-write scoreboard
module rv_regfile_sb
    import rv_regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int PEND_MAX = PEND_MAX_DEF,
    parameter int AW       = aw_of(NREGS),
    parameter int CW       = cw_of(PEND_MAX)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [NRD*AW-1:0]   RD_ADDR,
    output logic [NRD*XLEN-1:0] RD_DATA,
    output logic [NRD-1:0]      RD_BUSY,
    input  logic                WR_EN,
    input  logic [AW-1:0]       WR_ADDR,
    input  logic [XLEN-1:0]     WR_DATA,
    input  logic                ISSUE_EN,
    input  logic [AW-1:0]       ISSUE_ADDR,
    output logic                ISSUE_READY,
    input  logic                FLUSH
);
    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] nz, one, full;

    always_ff @(posedge CLK) begin
        if (RESET)
            for (int k = 0; k < NREGS; k++) mem[k] <= '0;
        else if (WR_EN && WR_ADDR != '0)
            mem[WR_ADDR] <= WR_DATA;
    end

    assign ISSUE_READY = !full[ISSUE_ADDR];

    for (genvar r = 0; r < NREGS; r++) begin : g_cnt
        if (r == 0) begin : g_zero
            assign nz[r]   = 1'b0;
            assign one[r]  = 1'b0;
            assign full[r] = 1'b0;
        end else begin : g_reg
            rv_regfile_pend_cnt #(.PEND_MAX(PEND_MAX), .CW(CW)) u_cnt (
                .CLK        (CLK),
                .rst        (RESET),
                .clr        (FLUSH),
                .inc        (ISSUE_EN && ISSUE_READY && ISSUE_ADDR == AW'(r)),
                .dec        (WR_EN && WR_ADDR == AW'(r)),
                .cnt_nz     (nz[r]),
                .cnt_is_one (one[r]),
                .full       (full[r])
            );
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] addr;
        logic          byp;
        assign addr = RD_ADDR[port_lsb(i, AW) +: AW];
        assign byp  = WR_EN && WR_ADDR == addr;
        assign RD_DATA[port_lsb(i, XLEN) +: XLEN] = addr == '0 ? '0 : byp ? WR_DATA : mem[addr];
        // the last outstanding write arriving now is covered by the bypass
        assign RD_BUSY[i] = nz[addr] && !(one[addr] && byp);
    end
endmodule

// File: tb/tb_rv_regfile_sb.sv
// tb_rv_regfile_sb: table-driven directed checks of read bypass, scoreboard, flush and reset
module tb_rv_regfile_sb;
    logic        CLK = 1'b0;
    logic        RESET;
    logic [9:0]  RD_ADDR;
    logic [63:0] RD_DATA;
    logic [1:0]  RD_BUSY;
    logic        WR_EN, ISSUE_EN, ISSUE_READY, FLUSH;
    logic [4:0]  WR_ADDR, ISSUE_ADDR;
    logic [31:0] WR_DATA;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst, we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ie;
        logic [4:0]  ia;
        logic        fl;
        logic [4:0]  ra0, ra1;
        logic [31:0] d0, d1;
        logic [1:0]  bz;
        logic        rdy;
    } vec_t;

    vec_t vecs[27];

    rv_regfile_sb dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .RD_ADDR     (RD_ADDR),
        .RD_DATA     (RD_DATA),
        .RD_BUSY     (RD_BUSY),
        .WR_EN       (WR_EN),
        .WR_ADDR     (WR_ADDR),
        .WR_DATA     (WR_DATA),
        .ISSUE_EN    (ISSUE_EN),
        .ISSUE_ADDR  (ISSUE_ADDR),
        .ISSUE_READY (ISSUE_READY),
        .FLUSH       (FLUSH)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t mk(input int unsigned rst, we, wa, wd, ie, ia, fl, ra0, ra1, d0, d1, bz, rdy);
        vec_t v;
        v.rst = 1'(rst); v.we = 1'(we); v.wa = 5'(wa); v.wd = wd;
        v.ie = 1'(ie); v.ia = 5'(ia); v.fl = 1'(fl);
        v.ra0 = 5'(ra0); v.ra1 = 5'(ra1); v.d0 = d0; v.d1 = d1;
        v.bz = 2'(bz); v.rdy = 1'(rdy);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // drive one cycle of inputs after the falling edge, check combinational outputs before the rising edge
    task automatic apply(input vec_t v, input string tag);
        @(negedge CLK);
        RESET = v.rst; WR_EN = v.we; WR_ADDR = v.wa; WR_DATA = v.wd;
        ISSUE_EN = v.ie; ISSUE_ADDR = v.ia; FLUSH = v.fl; RD_ADDR = {v.ra1, v.ra0};
        #1;
        check({tag, " d0"}, RD_DATA[31:0], v.d0);
        check({tag, " d1"}, RD_DATA[63:32], v.d1);
        check({tag, " busy"}, 32'(RD_BUSY), 32'(v.bz));
        check({tag, " ready"}, 32'(ISSUE_READY), 32'(v.rdy));
    endtask

    initial begin
        // reset, then x0 behaviour, bypass, WAW scoreboard, simultaneous issue+write, flush
        vecs[0]  = mk(0,1,5,32'hDEADBEEF,0,0,0,5,0,32'hDEADBEEF,0,0,1);
        vecs[1]  = mk(1,0,0,0,0,0,0,5,0,32'hDEADBEEF,0,0,1);
        vecs[2]  = mk(0,0,0,0,0,0,0,5,5,0,0,0,1);
        vecs[3]  = mk(0,1,0,32'h12345678,1,0,0,0,0,0,0,0,1);
        vecs[4]  = mk(0,0,0,0,0,0,0,0,0,0,0,0,1);
        vecs[5]  = mk(0,1,7,32'hA5A5A5A5,0,0,0,7,7,32'hA5A5A5A5,32'hA5A5A5A5,0,1);
        vecs[6]  = mk(0,0,0,0,0,0,0,7,7,32'hA5A5A5A5,32'hA5A5A5A5,0,1);
        vecs[7]  = mk(0,0,0,0,1,3,0,3,0,0,0,0,1);
        vecs[8]  = mk(0,0,0,0,1,3,0,3,0,0,0,1,1);
        vecs[9]  = mk(0,0,0,0,1,3,0,3,0,0,0,1,1);
        vecs[10] = mk(0,0,0,0,1,3,0,3,3,0,0,3,0);
        vecs[11] = mk(0,0,0,0,0,3,0,3,0,0,0,1,0);
        vecs[12] = mk(0,1,3,1,0,3,0,3,0,1,0,1,0);
        vecs[13] = mk(0,1,3,2,0,3,0,3,0,2,0,1,1);
        vecs[14] = mk(0,1,3,3,0,3,0,3,0,3,0,0,1);
        vecs[15] = mk(0,0,0,0,0,0,0,3,0,3,0,0,1);
        vecs[16] = mk(0,0,0,0,1,9,0,0,9,0,0,0,1);
        vecs[17] = mk(0,1,9,32'hBB,1,9,0,0,9,0,32'hBB,0,1);
        vecs[18] = mk(0,0,0,0,0,9,0,0,9,0,32'hBB,2,1);
        vecs[19] = mk(0,1,9,32'hCC,0,0,0,0,9,0,32'hCC,0,1);
        vecs[20] = mk(0,0,0,0,0,0,0,9,9,32'hCC,32'hCC,0,1);
        vecs[21] = mk(0,0,0,0,1,4,0,4,0,0,0,0,1);
        vecs[22] = mk(0,0,0,0,1,4,0,4,0,0,0,1,1);
        vecs[23] = mk(0,1,4,32'h77,1,4,1,4,0,32'h77,0,1,1);
        vecs[24] = mk(0,0,0,0,0,4,0,4,0,32'h77,0,0,1);
        vecs[25] = mk(0,1,4,32'h88,0,0,0,4,0,32'h88,0,0,1);
        vecs[26] = mk(0,0,0,0,0,0,0,4,0,32'h88,0,0,1);

        RESET = 1'b1; WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0;
        ISSUE_EN = 1'b0; ISSUE_ADDR = '0; FLUSH = 1'b0; RD_ADDR = '0;
        repeat (2) @(negedge CLK);

        for (int i = 0; i < 27; i++) apply(vecs[i], $sformatf("vec%0d", i));

        // reset mid-stream: pending x6 tracking and an in-flight x7 write are discarded
        apply(mk(0,0,0,0,1,6,0,6,0,0,0,0,1), "mid0");
        apply(mk(0,0,0,0,1,6,0,6,0,0,0,1,1), "mid1");
        apply(mk(1,1,7,32'h55,1,6,0,6,7,0,32'h55,1,1), "mid2");
        apply(mk(0,0,0,0,0,6,0,6,7,0,0,0,1), "mid3");
        apply(mk(0,1,6,32'h66,0,0,0,6,0,32'h66,0,0,1), "mid4");
        apply(mk(0,0,0,0,0,0,0,6,0,32'h66,0,0,1), "mid5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
